// File: rtl/mux_rr_sched.sv
// Round-robin scheduler for the 8:1 serializer mux: registered one-hot grant
// and select, with a bounded burst so that one lane cannot monopolise the mux.
module mux_rr_sched #(
    parameter int SEL_W     = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [2**SEL_W-1:0]   req,
    output logic [2**SEL_W-1:0]   grant,
    output logic [SEL_W-1:0]      sel,
    output logic                  valid_out,
    output logic                  busy
);
    localparam int N = 2**SEL_W;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [N-1:0]     grant_reg, grant_next;
    logic             valid_reg, valid_next;
    logic             busy_reg, busy_next;
    logic [3:0]       burst_reg, burst_next;

    logic [N-1:0]     rot_req;
    logic [SEL_W-1:0] found_off;
    logic [SEL_W-1:0] found_lane;

    // rot_req[0] is the lane after sel; the current lane lands in the top bit,
    // so it is scanned last.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign rot_req[gi] = req[sel_reg + SEL_W'(gi + 1)];
        end
    endgenerate

    always_comb begin
        found_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) found_off = SEL_W'(i);
        end
    end

    assign found_lane = sel_reg + found_off + SEL_W'(1);

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        grant_next = grant_reg;
        valid_next = valid_reg;
        busy_next  = busy_reg;
        burst_next = burst_reg;
        case (state_reg)
            IDLE: begin
                if (enable && (|req)) begin
                    state_next = GRANT;
                    sel_next   = found_lane;
                    grant_next = N'(1) << found_lane;
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                    burst_next = 4'd1;
                end else begin
                    grant_next = '0;
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                end
            end
            GRANT: begin
                if (!enable || !(|req)) begin
                    state_next = IDLE;
                    grant_next = '0;
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                end else if (req[sel_reg] && (burst_reg < 4'(MAX_BURST))) begin
                    burst_next = burst_reg + 4'd1;
                end else begin
                    // A lone requester whose burst expired is found again here.
                    sel_next   = found_lane;
                    grant_next = N'(1) << found_lane;
                    burst_next = 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                valid_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            sel_reg   <= '1;
            grant_reg <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            burst_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            grant_reg <= grant_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            burst_reg <= burst_next;
        end
    end

    assign grant     = grant_reg;
    assign sel       = sel_reg;
    assign valid_out = valid_reg;
    assign busy      = busy_reg;
endmodule
